// File: rtl/serial_word_queue_pkg.sv
// serial_word_queue_pkg: shared deserializer state type and occupancy-width helper
package serial_word_queue_pkg;
  typedef enum logic [1:0] {S_INIT, S_READY, S_STALL} deser_state_t;
  function automatic int len_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer queue with occupancy count and registered read data
module sync_fifo
  import serial_word_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int LEN_W = len_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic [LEN_W-1:0] count,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_pop, do_push;
  assign full = count == LEN_W'(DEPTH);
  assign do_pop = pop && count != '0;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_pop;
      if (do_pop) rd_data <= mem[rd_ptr];
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + LEN_W'(do_push) - LEN_W'(do_pop);
    end
  end
endmodule

// File: rtl/serial_word_queue.sv
// serial_word_queue: bit-serial word assembler feeding a word FIFO with stall or drop on full
module serial_word_queue
  import serial_word_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int MSB_FIRST = 0,
  parameter int DROP_ON_FULL = 0,
  localparam int LEN_W = len_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_in,
  input  logic             write_in,
  output logic             status_out,
  input  logic             dequeue_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic [LEN_W-1:0] len_out,
  output logic             overflow_out
);
  localparam int CW = $clog2(WIDTH);
  deser_state_t state, state_nx;
  logic [CW-1:0] cnt, idx;
  logic [WIDTH-1:0] sr, hold, word, push_data;
  logic bit_en, last, pop_ok, accept, push, full;
  assign status_out = state == S_READY;
  assign bit_en = status_out && write_in;
  assign last = bit_en && cnt == CW'(WIDTH - 1);
  assign pop_ok = dequeue_in && len_out != '0;
  assign accept = !full || pop_ok;
  assign push = (last || state == S_STALL) && accept;
  assign push_data = state == S_STALL ? hold : word;
  assign idx = MSB_FIRST != 0 ? CW'(WIDTH - 1) - cnt : cnt;
  always_comb begin
    word = sr;
    word[idx] = data_in;
  end
  always_comb begin
    state_nx = state;
    state_nx = state == S_INIT ? S_READY :
               state == S_STALL ? (accept ? S_READY : S_STALL) :
               (last && !accept && DROP_ON_FULL == 0) ? S_STALL : S_READY;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_INIT;
      cnt <= '0;
      sr <= '0;
      hold <= '0;
      overflow_out <= 1'b0;
    end else begin
      state <= state_nx;
      overflow_out <= last && !accept && DROP_ON_FULL != 0;
      if (bit_en) sr <= word;
      if (bit_en) cnt <= last ? '0 : cnt + 1'b1;
      if (last) hold <= word;
    end
  end
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .push_data(push_data),
    .pop(dequeue_in),
    .full(full),
    .count(len_out),
    .rd_data(data_out),
    .rd_valid(valid_out)
  );
endmodule

// File: doc/serial_word_queue.md
# serial_word_queue

Parametrised successor to the team's serial-deserializer-plus-queue top, on a single clock. It accepts a bit stream qualified by `write_in` and assembles `WIDTH`-bit words with a selectable bit order. Completed words go into a `DEPTH`-entry FIFO, which a consumer drains with `dequeue_in`. Unlike the previous generation, it adds:
- generic width and depth;
- MSB/LSB-first assembly;
- back-pressure on a full queue, or a drop mode that signals overflow.

## Interface
Parameters:
- `WIDTH`, 8: word width in bits; must be ≥ 2.
- `DEPTH`, 8: number of queue entries; must be a power of two and ≥ 2.
- `MSB_FIRST`, 0: 0 means the first serial bit is bit 0; 1 means the first serial bit is bit `WIDTH-1`.
- `DROP_ON_FULL`, 0: 0 means stall the sender when the queue is full; 1 means discard the word and pulse `overflow_out`.
- `LEN_W`, derived as `$clog2(DEPTH+1)`.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: the only clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `data_in` in 1: serial bit, sampled when `write_in`=1 and `status_out`=1.
- `write_in` in 1: bit strobe, one bit per high cycle.
- `status_out` out 1: 1 = ready to accept bits.
- `dequeue_in` in 1: pop request, one word per high cycle.
- `data_out` out `WIDTH`: last popped word.
- `valid_out` out 1: one-cycle pulse when `data_out` is updated by a pop.
- `len_out` out `LEN_W`: current queue occupancy, 0..`DEPTH`.
- `overflow_out` out 1: one-cycle pulse when a word is dropped (only when `DROP_ON_FULL`=1).

## Operation
- Deserializer FSM states: `S_INIT`, `S_READY`, `S_STALL`.
  - `S_INIT`: entered on reset. `status_out`=0. Moves to `S_READY` on the first edge with `reset`=0.
  - `S_READY`: `status_out`=1.
    - Each edge with `write_in`=1 shifts `data_in` into the shift register and increments the bit counter (`$clog2(WIDTH)` bits).
    - The counter wraps to 0 after bit `WIDTH-1`.
  - `S_STALL`: `status_out`=0. The completed word is parked in a holding register.
- A `write_in` edge while `status_out`=0 is ignored: no bit is counted.
- Final-bit edge E: the assembled word (shift register merged with the current `data_in`) is offered to the queue at E.
  - Push is accepted if `len_out` < `DEPTH`, or if a pop happens at the same edge E.
  - If not accepted and `DROP_ON_FULL`=0: the FSM goes to `S_STALL`, holding the word.
  - If not accepted and `DROP_ON_FULL`=1: the word is discarded, `overflow_out`=1 for the cycle after E, and the FSM stays in `S_READY`.
- Leaving `S_STALL`: the held word is pushed on the first edge where `len_out` < `DEPTH` or `dequeue_in`=1. The FSM returns to `S_READY` at that edge.
- Bit order:
  - `MSB_FIRST`=0: bit k of the stream goes to word bit k.
  - `MSB_FIRST`=1: bit k of the stream goes to word bit `WIDTH-1-k`.
- Queue: circular buffer with `$clog2(DEPTH)`-bit read/write pointers, wrapping naturally.
  - Pop edge (`dequeue_in`=1, `len_out`>0): `data_out` takes the head entry, `valid_out`=1 next cycle, read pointer advances.
  - `dequeue_in` with an empty queue: ignored; `valid_out`=0 and `data_out` holds its value.
  - Simultaneous push and pop: `len_out` is unchanged.
  - Push when full with a simultaneous pop: allowed; the read of the old head happens before the write.
- Reset mid-word or mid-stall: the partial word and the held word are discarded and the queue is emptied.

## Timing
- Reset values: `status_out`=0, `data_out`=0, `valid_out`=0, `len_out`=0, `overflow_out`=0; pointers, bit counter and shift register all 0.
- `status_out` rises one cycle after `reset` deasserts.
- Final bit to `len_out` increment: visible one cycle after edge E, with no extra latency.
- Pop to `data_out`/`valid_out`: one cycle, registered.
- `status_out` falls the cycle after E when stalling. It rises the cycle after the unblocking edge.
- `write_in` may be held high across consecutive cycles: one bit per cycle, full rate.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `serial_word_queue_pkg`:
  - `deser_state_t` enum (`S_INIT`, `S_READY`, `S_STALL`);
  - localparam helper for `LEN_W`.
- Sub-module `sync_fifo #(WIDTH, DEPTH)`: push/pop/full/count, registered read data.
- The top level holds the deserializer FSM, shift register, holding register and overflow logic.

## Test plan
- Reset: hold `reset` for 3 cycles, then release → all outputs 0 during reset, `status_out`=1 exactly one cycle after release.
- Default parameters, send words 0x00, 0x01, 0x02, 0x03 LSB-first → `len_out`=4. Then assert `dequeue_in` for 4 cycles → `data_out` 0x00, 0x01, 0x02, 0x03 on consecutive `valid_out` pulses, `len_out`=0. A fifth dequeue gives no `valid_out`.
- Bit order: stream 0,0,0,0,1,1,1,1 → 0xF0 with `MSB_FIRST`=0, and 0x0F with `MSB_FIRST`=1.
- Stall mode, `DEPTH`=8: fill with 0x10..0x17, then send 0x18 → `status_out`=0 after the final bit, and extra `write_in` pulses are ignored. Dequeue once → `data_out`=0x10, `len_out` stays 8, `status_out` back to 1, and the 0x18 word is read last.
- Drop mode: fill with 8 words, send 0x18 → one `overflow_out` pulse, `len_out`=8, `status_out` stays 1, and 0x18 never appears on `data_out`.
- Full queue with final bit and `dequeue_in` on the same edge → no stall, `len_out` stays 8.
- Reset mid-word: 3 bits, then `reset`, then 0x55 → the queue holds only 0x55.
